// File: rtl/simon_pkg.sv
// Shared types and constants for the colour-sequence datapath.
package simon_pkg;

  typedef logic [1:0] colour_t;

  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam int          MAX_ROUND_DEF = 32;

  // Decoded strobe after priority resolution; only one acts per cycle.
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_ADD,
    CMD_PSTART,
    CMD_PULSE,
    CMD_CHECK,
    CMD_START,
    CMD_SEED,
    CMD_SPEED
  } cmd_t;

  function automatic logic [3:0] onehot(input colour_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, taps 16,14,13,11, advancing every cycle.
module lfsr16
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (reset || load)
      q <= LFSR_SEED;
    else
      q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/seq_datapath.sv
// Colour-sequence store, playback timer and player checker.
// Optional: define SIMON_LFSR_EN to append LFSR-derived colours instead of 0,1,2,3,...
module seq_datapath
  import simon_pkg::*;
#(
  parameter int PULSE_BASE = 25_000_000,
  parameter int MAX_ROUND  = MAX_ROUND_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       seed_rst,
  input  logic       start_rng,
  input  logic       add_clr,
  input  logic       inc_speed,
  input  logic       pulse_on,
  input  logic       player_start,
  input  logic       check_move,
  input  logic       fail_on,
  input  logic [3:0] player_input,
  output logic       pulse,
  output logic [5:0] check_round,
  output logic       result,
  output logic [5:0] current_round,
  output logic [3:0] led
);

  localparam int              AW    = (MAX_ROUND > 1) ? $clog2(MAX_ROUND) : 1;
  localparam int              TW    = $clog2(PULSE_BASE + 1);
  localparam logic [TW-1:0]   PB    = TW'(PULSE_BASE);
  localparam logic [5:0]      MAX_R = 6'(MAX_ROUND);

  cmd_t          cmd_p0;
  colour_t       mem [MAX_ROUND];
  colour_t       mem_rd;
  colour_t       new_colour;
  colour_t       exp_colour_p1;
  logic [5:0]    rd_ptr;
  logic [1:0]    speed;
  logic [TW-1:0] timer;
  logic [TW-1:0] period;
  logic          pulse_fire;
  logic [3:0]    led_r;

  // Stage p0: strobe priority resolution
  always_comb begin
    cmd_p0 = CMD_NONE;
    if      (add_clr)      cmd_p0 = CMD_ADD;
    else if (player_start) cmd_p0 = CMD_PSTART;
    else if (pulse_on)     cmd_p0 = CMD_PULSE;
    else if (check_move)   cmd_p0 = CMD_CHECK;
    else if (start_rng)    cmd_p0 = CMD_START;
    else if (seed_rst)     cmd_p0 = CMD_SEED;
    else if (inc_speed)    cmd_p0 = CMD_SPEED;
  end

`ifdef SIMON_LFSR_EN
  logic [15:0] lfsr_q;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (cmd_p0 == CMD_SEED),
    .q     (lfsr_q)
  );

  assign new_colour = lfsr_q[1:0];
`else
  assign new_colour = current_round[1:0];
`endif

  assign mem_rd     = mem[rd_ptr[AW-1:0]];
  assign period     = PB >> speed;
  assign pulse_fire = (timer >= period - TW'(1));

  // Sequence memory holds data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (!reset && cmd_p0 == CMD_ADD && current_round < MAX_R)
      mem[current_round[AW-1:0]] <= new_colour;
  end

  // Display period timer; a pulse_on that wins priority restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
      pulse <= 1'b0;
    end else if (cmd_p0 == CMD_PULSE) begin
      timer <= '0;
      pulse <= 1'b0;
    end else if (pulse_fire) begin
      timer <= '0;
      pulse <= 1'b1;
    end else begin
      timer <= timer + TW'(1);
      pulse <= 1'b0;
    end
  end

  // Stage p1: round counters, playback display and move check
  always_ff @(posedge clk) begin
    if (reset) begin
      current_round <= '0;
      check_round   <= '0;
      rd_ptr        <= '0;
      speed         <= '0;
      result        <= 1'b0;
      led_r         <= '0;
    end else begin
      if (pulse_fire)
        led_r <= '0;
      case (cmd_p0)
        CMD_ADD: begin
          if (current_round < MAX_R) begin
            current_round <= current_round + 6'd1;
            check_round   <= current_round + 6'd1;
          end else begin
            check_round   <= current_round;
          end
          rd_ptr <= '0;
        end
        CMD_PSTART: begin
          check_round <= current_round;
          rd_ptr      <= '0;
          led_r       <= '0;
        end
        CMD_PULSE: begin
          if (check_round != 6'd0) begin
            led_r       <= onehot(mem_rd);
            rd_ptr      <= rd_ptr + 6'd1;
            check_round <= check_round - 6'd1;
          end
        end
        CMD_CHECK: begin
          result <= (player_input == onehot(mem_rd));
          // Pointer only advances with a remaining move so it never leaves the written range.
          if (check_round != 6'd0) begin
            rd_ptr      <= rd_ptr + 6'd1;
            check_round <= check_round - 6'd1;
          end
        end
        CMD_START: begin
          current_round <= '0;
          check_round   <= '0;
          rd_ptr        <= '0;
          speed         <= '0;
          led_r         <= '0;
        end
        CMD_SPEED: begin
          if (speed != 2'd3)
            speed <= speed + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // The expected colour is data: latched on every accepted check, no reset.
  always_ff @(posedge clk) begin
    if (cmd_p0 == CMD_CHECK)
      exp_colour_p1 <= mem_rd;
  end

  assign led = fail_on ? onehot(exp_colour_p1) : led_r;

endmodule

// File: tb/tb_seq_datapath.sv
// Directed bench for seq_datapath with PULSE_BASE=8, default (non-LFSR) colour pattern.
module tb_seq_datapath;

  logic       clk = 1'b0;
  logic       reset, seed_rst, start_rng, add_clr, inc_speed, pulse_on;
  logic       player_start, check_move, fail_on;
  logic [3:0] player_input;
  logic       pulse;
  logic [5:0] check_round;
  logic       result;
  logic [5:0] current_round;
  logic [3:0] led;

  int checks   = 0;
  int failures = 0;
  int n;

  seq_datapath #(.PULSE_BASE(8), .MAX_ROUND(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .seed_rst     (seed_rst),
    .start_rng    (start_rng),
    .add_clr      (add_clr),
    .inc_speed    (inc_speed),
    .pulse_on     (pulse_on),
    .player_start (player_start),
    .check_move   (check_move),
    .fail_on      (fail_on),
    .player_input (player_input),
    .pulse        (pulse),
    .check_round  (check_round),
    .result       (result),
    .current_round(current_round),
    .led          (led)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_add();
    add_clr = 1'b1; tick(); add_clr = 1'b0;
  endtask

  task automatic do_pulse_on();
    pulse_on = 1'b1; tick(); pulse_on = 1'b0;
  endtask

  task automatic do_check(input logic [3:0] pin);
    player_input = pin; check_move = 1'b1; tick(); check_move = 1'b0;
  endtask

  task automatic do_speed();
    inc_speed = 1'b1; tick(); inc_speed = 1'b0;
  endtask

  // Restart the timer and count cycles to the first pulse (64 = timed out).
  task automatic measure(output int cnt);
    do_pulse_on();
    cnt = 0;
    while (cnt < 64) begin
      tick();
      cnt++;
      if (pulse) break;
    end
  endtask

  initial begin
    reset = 1'b1; seed_rst = 0; start_rng = 0; add_clr = 0; inc_speed = 0;
    pulse_on = 0; player_start = 0; check_move = 0; fail_on = 0; player_input = 4'b0;
    tick(); tick();
    reset = 1'b0;
    check_val("rst_cur",    32'(current_round), 0);
    check_val("rst_chk",    32'(check_round),   0);
    check_val("rst_result", 32'(result),        0);
    check_val("rst_pulse",  32'(pulse),         0);
    check_val("rst_led",    32'(led),           0);

    start_rng = 1'b1; tick(); start_rng = 1'b0;
    do_add(); do_add(); do_add();
    check_val("add3_cur", 32'(current_round), 3);
    check_val("add3_chk", 32'(check_round),   3);

    // Playback of mem[0]=0, timer restarted by pulse_on
    do_pulse_on();
    check_val("play0_led", 32'(led),         4'b0001);
    check_val("play0_chk", 32'(check_round), 2);
    for (int i = 1; i <= 7; i++) tick();
    check_val("pre_pulse",     32'(pulse), 0);
    check_val("pre_pulse_led", 32'(led),   4'b0001);
    tick();
    check_val("pulse_at_8",  32'(pulse), 1);
    check_val("led_cleared", 32'(led),   0);
    tick();
    check_val("pulse_one_cycle", 32'(pulse), 0);

    do_pulse_on();
    check_val("play1_led", 32'(led), 4'b0010);
    do_pulse_on();
    check_val("play2_led", 32'(led),         4'b0100);
    check_val("play2_chk", 32'(check_round), 0);
    n = 0;
    while (n < 64 && !pulse) begin tick(); n++; end
    check_val("wait_pulse", 32'(pulse), 1);
    do_pulse_on();
    check_val("play_empty_led", 32'(led),           0);
    check_val("play_empty_chk", 32'(check_round),   0);
    check_val("play_empty_cur", 32'(current_round), 3);

    // Player checking: mem = {0,1,2}
    player_start = 1'b1; tick(); player_start = 1'b0;
    check_val("pstart_chk", 32'(check_round), 3);
    do_check(4'b0001);
    check_val("chk_match",   32'(result),      1);
    check_val("chk_match_c", 32'(check_round), 2);
    do_check(4'b0100);
    check_val("chk_miss", 32'(result), 0);
    fail_on = 1'b1; #1;
    check_val("fail_led", 32'(led), 4'b0010);
    fail_on = 1'b0; #1;
    check_val("fail_off_led", 32'(led), 0);
    do_check(4'b0101);
    check_val("chk_multihot", 32'(result),      0);
    check_val("chk_done",     32'(check_round), 0);
    player_start = 1'b1; tick(); player_start = 1'b0;
    do_check(4'b0000);
    check_val("chk_zero", 32'(result), 0);
    do_check(4'b0010);
    check_val("chk_match2", 32'(result), 1);

    // Priority: add_clr beats pulse_on and check_move in the same cycle
    player_start = 1'b1; tick(); player_start = 1'b0;
    add_clr = 1'b1; pulse_on = 1'b1; check_move = 1'b1; player_input = 4'b1000;
    tick();
    add_clr = 1'b0; pulse_on = 1'b0; check_move = 1'b0;
    check_val("prio_cur",    32'(current_round), 4);
    check_val("prio_chk",    32'(check_round),   4);
    check_val("prio_led",    32'(led),           0);
    check_val("prio_result", 32'(result),        1);

    // Speed levels: 8 >> level, saturating at level 3
    start_rng = 1'b1; tick(); start_rng = 1'b0;
    measure(n);
    check_val("period_l0", 32'(n), 8);
    do_speed(); do_speed();
    measure(n);
    check_val("period_l2", 32'(n), 2);
    do_speed(); do_speed();
    measure(n);
    check_val("period_l3", 32'(n), 1);
    do_speed();
    measure(n);
    check_val("period_sat", 32'(n), 1);

    // Capacity saturation
    start_rng = 1'b1; tick(); start_rng = 1'b0;
    for (int i = 0; i < 32; i++) do_add();
    check_val("cap_cur32", 32'(current_round), 32);
    do_add();
    check_val("cap_cur_sat", 32'(current_round), 32);
    check_val("cap_chk",     32'(check_round),   32);

    // Reset during playback
    start_rng = 1'b1; tick(); start_rng = 1'b0;
    do_add(); do_add(); do_add();
    do_pulse_on(); do_pulse_on(); do_pulse_on();
    check_val("mid_play_led", 32'(led), 4'b0100);
    reset = 1'b1; tick(); reset = 1'b0;
    check_val("abort_led",   32'(led),           0);
    check_val("abort_cur",   32'(current_round), 0);
    check_val("abort_chk",   32'(check_round),   0);
    check_val("abort_pulse", 32'(pulse),         0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
